// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Holds the default sizes, the address-width derivation and the PC index.
package reg_file_pkg;

  localparam int DEF_N    = 32;
  localparam int DEF_NREG = 16;

  function automatic int addr_width(input int nreg);
    return $clog2(nreg);
  endfunction

  // The top register always holds the program counter.
  function automatic int pc_index(input int nreg);
    return nreg - 1;
  endfunction

  localparam int PC_IDX = pc_index(DEF_NREG);

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one reservation bit per register, plus STALL and BUSY_ANY.
// STALL semantics depend on REG_FILE_SB_BYPASS_EN (bypassed load return does not stall).
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  localparam int AW  = addr_width(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic          we4,
  input  logic [AW-1:0] addr4,
  input  logic          res_en,
  input  logic [AW-1:0] res_addr,
  output logic          stall,
  output logic          busy_any
);

  localparam int            PC   = pc_index(NREG);
  localparam logic [AW-1:0] PC_A = AW'(PC);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bits
      // The PC can never be reserved, so its set term is tied low.
      assign set_vec[gi] = (gi != PC) && res_en && (res_addr == AW'(gi));
      assign clr_vec[gi] = we4 && (addr4 == AW'(gi));
    end
  endgenerate

  // Set after clear: a reservation issued alongside a load return survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg & ~clr_vec) | set_vec;
    end
  end

  logic hit1;
  logic hit2;
  logic stall1;
  logic stall2;

  assign hit1 = we4 && (addr4 == addr1);
  assign hit2 = we4 && (addr4 == addr2);

`ifdef REG_FILE_SB_BYPASS_EN
  assign stall1 = (addr1 != PC_A) && busy_reg[addr1] && !hit1;
  assign stall2 = (addr2 != PC_A) && busy_reg[addr2] && !hit2;
`else
  // Without bypass the returning value is not visible until next cycle.
  assign stall1 = (addr1 != PC_A) && (busy_reg[addr1] || hit1);
  assign stall2 = (addr2 != PC_A) && (busy_reg[addr2] || hit2);
`endif

  assign stall    = stall1 || stall2;
  assign busy_any = |busy_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with PC register and load scoreboard.
// Optional write-through bypass enabled by macro REG_FILE_SB_BYPASS_EN.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int NREG = DEF_NREG,
  localparam int AW  = addr_width(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [N-1:0]  RD1,
  output logic [N-1:0]  RD2,
  input  logic          WE3,
  input  logic [AW-1:0] A3,
  input  logic [N-1:0]  WD3,
  input  logic          WE4,
  input  logic [AW-1:0] A4,
  input  logic [N-1:0]  WD4,
  input  logic          RES_EN,
  input  logic [AW-1:0] RES_A,
  input  logic [N-1:0]  R15,
  output logic          STALL,
  output logic          BUSY_ANY
);

  localparam int PC = pc_index(NREG);

  logic [N-1:0] regs_reg [NREG];

  // PC reloads every edge; ALU writes take priority over load returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == PC)                     regs_reg[i] <= R15;
        else if (WE3 && A3 == AW'(i))    regs_reg[i] <= WD3;
        else if (WE4 && A4 == AW'(i))    regs_reg[i] <= WD4;
      end
    end
  end

`ifdef REG_FILE_SB_BYPASS_EN
  localparam logic [AW-1:0] PC_A = AW'(PC);

  function automatic logic [N-1:0] bypass_read(
    input logic [AW-1:0] a,
    input logic [N-1:0]  stored,
    input logic          we3,
    input logic [AW-1:0] a3,
    input logic [N-1:0]  wd3,
    input logic          we4,
    input logic [AW-1:0] a4,
    input logic [N-1:0]  wd4
  );
    if (a == PC_A)             return stored;
    if (we3 && a3 == a)        return wd3;
    if (we4 && a4 == a)        return wd4;
    return stored;
  endfunction

  assign RD1 = bypass_read(A1, regs_reg[A1], WE3, A3, WD3, WE4, A4, WD4);
  assign RD2 = bypass_read(A2, regs_reg[A2], WE3, A3, WD3, WE4, A4, WD4);
`else
  assign RD1 = regs_reg[A1];
  assign RD2 = regs_reg[A2];
`endif

  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .addr1    (A1),
    .addr2    (A2),
    .we4      (WE4),
    .addr4    (A4),
    .res_en   (RES_EN),
    .res_addr (RES_A),
    .stall    (STALL),
    .busy_any (BUSY_ANY)
  );

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter N, default 32: register width in bits.
REQ-002 SHALL have parameter NREG, default 16: register count, power of two, 4..64; AW = log2(NREG).
REQ-003 SHALL use one clock, clk; reset is rst, asynchronous and active-low.
REQ-004 SHALL provide these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  async active-low reset
- A1, A2  in  AW  read addresses
- RD1, RD2  out  N  read data
- WE3  in  1  ALU write enable
- A3  in  AW  ALU write address
- WD3  in  N  ALU write data
- WE4  in  1  load-return write enable
- A4  in  AW  load-return write address
- WD4  in  N  load-return write data
- RES_EN  in  1  reserve a register for a pending load
- RES_A  in  AW  address to reserve
- R15  in  N  next PC value
- STALL  out  1  a read operand is pending
- BUSY_ANY  out  1  at least one reservation is outstanding

Function
REQ-005 SHALL hold NREG registers; register NREG-1 (PC) SHALL load R15 on every clock edge and SHALL ignore WE3/WE4 writes.
REQ-006 SHALL write WD3 to register A3 on the clock edge when WE3=1, and WD4 to register A4 when WE4=1.
REQ-007 SHALL let WE3 win when WE3=WE4=1 with A3==A4; the WD4 value is discarded.
REQ-008 SHALL keep a busy bit per register; RES_EN=1 SHALL set busy[RES_A] at the next edge.
REQ-009 SHALL clear busy[A4] at the edge when WE4=1, even when WE3 wins the data write for that address (REQ-007).
REQ-010 SHALL let set win when a set and a clear hit the same address in the same cycle.
REQ-011 SHALL ignore RES_EN with RES_A==NREG-1.
REQ-012 SHALL drive RD1/RD2 combinationally with zero cycles of read latency.
REQ-013 SHALL return the stored PC register value on a read of NREG-1, never bypassed.
REQ-014 SHALL assert STALL combinationally when, for either port, busy[Ax]=1 and Ax is not NREG-1 and not (WE4=1 and A4==Ax).
REQ-015 SHALL set BUSY_ANY = OR of all busy bits, from registered state only.

Reset
REQ-016 SHALL, while rst=0, force all registers including PC to 0 and all busy bits to 0, so STALL=0 and BUSY_ANY=0.
REQ-017 SHALL, on reset mid-operation, drop all outstanding reservations; a later WE4 to a non-busy address SHALL still write its data.

Configuration
REQ-018 SHALL compile write-through bypass in only when macro REG_FILE_SB_BYPASS_EN is defined.
REQ-019 With REG_FILE_SB_BYPASS_EN defined, a read of Ax SHALL return WD3 if WE3=1 and A3==Ax; otherwise WD4 if WE4=1 and A4==Ax; otherwise the stored value.
REQ-020 Without REG_FILE_SB_BYPASS_EN, reads SHALL return stored values only, and STALL SHALL also assert when WE4=1 and A4==Ax, with Ax not NREG-1.

Structure
REQ-021 SHALL place default N/NREG constants, the AW derivation function and the PC index constant in shared package reg_file_pkg.
REQ-022 SHALL implement the busy-bit array, STALL and BUSY_ANY logic in sub-module reg_scoreboard.

Verification
REQ-023 Bench SHALL cover: reset release, then WE3=1, A3=2, WD3=0xDEADBEEF; next cycle A1=2 -> RD1=0xDEADBEEF, STALL=0.
REQ-024 Bench SHALL cover: WE3=WE4=1, A3=A4=5, WD3=0x11, WD4=0x22 -> next cycle register 5 reads 0x11 and busy[5]=0.
REQ-025 Bench SHALL cover: RES_EN=1, RES_A=7; next cycle A2=7 -> STALL=1, BUSY_ANY=1; WE4=1, A4=7, WD4=0x55 -> RD2=0x55 and STALL=0 that cycle with bypass, STALL=1 without bypass; following cycle BUSY_ANY=0.
REQ-026 Bench SHALL cover: WE3=1, A3=15, WD3=0x99, R15=0x100 -> next cycle reading 15 returns 0x100; RES_EN=1, RES_A=15 -> BUSY_ANY stays 0.
REQ-027 Bench SHALL cover: RES_EN=1, RES_A=3 together with WE4=1, A4=3 -> busy[3]=1 next cycle.
REQ-028 Bench SHALL cover: reserve registers 4 and 6, assert rst=0 for one cycle -> BUSY_ANY=0, STALL=0, all reads return 0.
